// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the memory-stage access bridge.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/mem_access_bridge_if.sv
// CPU-side request and SRAM-like bus signals of the access bridge.
// master = the bridge itself, slave = pipeline plus memory around it.
interface mem_access_bridge_if;
    logic        cpu_en;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wmask;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        bus_err;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        input  cpu_en, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        output cpu_rdata, cpu_stall, bus_err,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output cpu_en, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
        input  cpu_rdata, cpu_stall, bus_err,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_timeout_counter.sv
// Watchdog for outstanding bus accesses; held at zero while cleared,
// counts while running and flags once the count reaches LIMIT.
module mem_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clka,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    logic [7:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == 8'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_access_bridge.sv
// M-stage load/store to SRAM-like bus bridge (address phase, data phase).
// Optional watchdog: define MEM_BRIDGE_TIMEOUT_EN.
module mem_access_bridge
    import mem_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                clka,
    input  logic                rst,
    mem_access_bridge_if.master bif
);
    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timeout;
    logic        drive;
    logic [1:0]  store_size;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    mem_timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clka    (clka),
        .rst     (rst),
        .clear   (state_q == ST_IDLE),
        .run     ((state_q == ST_ADDR) || (state_q == ST_DATA)),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bif.cpu_en) begin
                    we_d    = bif.cpu_we;
                    addr_d  = bif.cpu_addr;
                    wdata_d = bif.cpu_wdata;
                    mask_d  = bif.cpu_wmask;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (timeout)               state_d = ST_DONE;
                else if (bif.bus_addr_ok)  state_d = ST_DATA;
            end
            ST_DATA: begin
                if (timeout) begin
                    state_d = ST_DONE;
                end else if (bif.bus_data_ok) begin
                    if (!we_q) rdata_d = bif.bus_rdata;
                    state_d = ST_DONE;
                end
            end
            // DONE never looks at cpu_en, so the same instruction is not reissued
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Size follows the number of enabled lanes; odd masks fall back to word
    always_comb begin
        case ($countones(mask_q))
            1:       store_size = SIZE_BYTE;
            2:       store_size = SIZE_HALF;
            default: store_size = SIZE_WORD;
        endcase
    end

    assign drive = (state_q == ST_ADDR) && !timeout;

    always_comb begin
        bif.bus_req   = drive;
        bif.bus_wr    = 1'b0;
        bif.bus_size  = SIZE_BYTE;
        bif.bus_addr  = '0;
        bif.bus_wstrb = '0;
        bif.bus_wdata = '0;
        if (drive) begin
            bif.bus_wr    = we_q;
            bif.bus_wdata = wdata_q;
            if (we_q) begin
                bif.bus_size  = store_size;
                bif.bus_addr  = addr_q;
                bif.bus_wstrb = mask_q;
            end else begin
                bif.bus_size  = SIZE_WORD;
                bif.bus_addr  = {addr_q[31:2], 2'b00};
            end
        end
    end

    assign bif.cpu_stall = bif.cpu_en && (state_q != ST_DONE);
    assign bif.cpu_rdata = rdata_q;
    assign bif.bus_err   = timeout;
endmodule

// File: tb/tb_mem_access_bridge.sv
// Directed bench for mem_access_bridge: stimulus queues expectations,
// a negedge monitor checks bus acceptances and pipeline release cycles.
module tb_mem_access_bridge;
    import mem_bridge_pkg::*;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    localparam int TB_TIMEOUT = 10;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        int          req_cycles;
    } exp_bus_t;

    typedef struct {
        logic [31:0] rdata;
        int          stall_cycles;
        logic        err;
    } exp_done_t;

    logic clka = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   passes = 0;

    exp_bus_t  exp_bus_q[$];
    exp_done_t exp_done_q[$];

    mem_access_bridge_if bif();

    mem_access_bridge #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .clka (clka),
        .rst  (rst),
        .bif  (bif)
    );

    always #5 clka = ~clka;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor
    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic        err_seen = 1'b0;
    logic        prev_req = 1'b0;
    logic [70:0] prev_fields = '0;

    always @(negedge clka) begin
        logic [70:0] cur;
        exp_bus_t    eb;
        exp_done_t   ed;
        if (rst) begin
            stall_cnt = 0;
            req_cnt   = 0;
            err_seen  = 1'b0;
            prev_req  = 1'b0;
        end else begin
            if (bif.cpu_en && bif.cpu_stall) stall_cnt++;
            if (bif.bus_err) err_seen = 1'b1;
            cur = {bif.bus_wr, bif.bus_size, bif.bus_addr, bif.bus_wstrb, bif.bus_wdata};
            if (bif.bus_req) begin
                req_cnt++;
                chk("req_needs_en", 72'(bif.cpu_en), 72'(1));
                if (prev_req) chk("bus_stable", 72'(cur), 72'(prev_fields));
                prev_fields = cur;
            end
            prev_req = bif.bus_req;
            if (bif.bus_req && bif.bus_addr_ok) begin
                chk("bus_q_nonempty", 72'(exp_bus_q.size() != 0), 72'(1));
                if (exp_bus_q.size() != 0) begin
                    eb = exp_bus_q.pop_front();
                    chk("bus_wr",    72'(bif.bus_wr),    72'(eb.wr));
                    chk("bus_size",  72'(bif.bus_size),  72'(eb.size));
                    chk("bus_addr",  72'(bif.bus_addr),  72'(eb.addr));
                    chk("bus_wstrb", 72'(bif.bus_wstrb), 72'(eb.wstrb));
                    chk("bus_wdata", 72'(bif.bus_wdata), 72'(eb.wdata));
                    chk("req_cycles", 72'(req_cnt),      72'(eb.req_cycles));
                end
            end
            if (bif.cpu_en && !bif.cpu_stall) begin
                chk("done_q_nonempty", 72'(exp_done_q.size() != 0), 72'(1));
                if (exp_done_q.size() != 0) begin
                    ed = exp_done_q.pop_front();
                    chk("cpu_rdata",    72'(bif.cpu_rdata), 72'(ed.rdata));
                    chk("stall_cycles", 72'(stall_cnt),     72'(ed.stall_cycles));
                    chk("bus_err_seen", 72'(err_seen),      72'(ed.err));
                end
                stall_cnt = 0;
                req_cnt   = 0;
                err_seen  = 1'b0;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [31:0] rd, input int aok_dly,
                          input logic send_data, input exp_bus_t eb, input exp_done_t ed);
        int n;
        exp_bus_q.push_back(eb);
        exp_done_q.push_back(ed);
        bif.cpu_en    = 1'b1;
        bif.cpu_we    = we;
        bif.cpu_addr  = addr;
        bif.cpu_wdata = wdata;
        bif.cpu_wmask = mask;
        n = 0;
        @(posedge clka); #1;
        while (!bif.bus_req && n < 20) begin
            @(posedge clka); #1;
            n++;
        end
        chk("req_wait", 72'(bif.bus_req), 72'(1));
        if (!bif.bus_req) begin
            bif.cpu_en = 1'b0;
            return;
        end
        repeat (aok_dly) begin
            @(posedge clka); #1;
        end
        bif.bus_addr_ok = 1'b1;
        @(posedge clka); #1;
        bif.bus_addr_ok = 1'b0;
        if (send_data) begin
            bif.bus_data_ok = 1'b1;
            bif.bus_rdata   = rd;
        end
        n = 0;
        while (bif.cpu_stall && n < 300) begin
            @(posedge clka); #1;
            bif.bus_data_ok = 1'b0;
            n++;
        end
        chk("done_wait", 72'(bif.cpu_stall), 72'(0));
        @(posedge clka); #1;
        bif.cpu_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bif.cpu_en      = 1'b0;
        bif.cpu_we      = 1'b0;
        bif.cpu_addr    = '0;
        bif.cpu_wdata   = '0;
        bif.cpu_wmask   = '0;
        bif.bus_addr_ok = 1'b0;
        bif.bus_data_ok = 1'b0;
        bif.bus_rdata   = '0;

        repeat (2) @(posedge clka);
        #1;
        chk("rst_bus_req",   72'(bif.bus_req),   72'(0));
        chk("rst_bus_wr",    72'(bif.bus_wr),    72'(0));
        chk("rst_bus_size",  72'(bif.bus_size),  72'(0));
        chk("rst_bus_addr",  72'(bif.bus_addr),  72'(0));
        chk("rst_bus_wstrb", 72'(bif.bus_wstrb), 72'(0));
        chk("rst_bus_wdata", 72'(bif.bus_wdata), 72'(0));
        chk("rst_cpu_rdata", 72'(bif.cpu_rdata), 72'(0));
        chk("rst_bus_err",   72'(bif.bus_err),   72'(0));
        chk("rst_cpu_stall", 72'(bif.cpu_stall), 72'(0));
        rst = 1'b0;
        @(posedge clka); #1;

        // Load, minimum latency
        access(0, 32'h1000_0006, 32'h0, 4'b0000, 32'hA5A5_1234, 0, 1,
               '{0, SIZE_WORD, 32'h1000_0004, 4'b0000, 32'h0, 1}, '{32'hA5A5_1234, 3, 0});
        @(posedge clka); #1;

        // Stores: read data on the bus must not disturb cpu_rdata
        access(1, 32'h0000_2002, 32'hBEEF_0000, 4'b1100, 32'h1111_2222, 0, 1,
               '{1, SIZE_HALF, 32'h0000_2002, 4'b1100, 32'hBEEF_0000, 1}, '{32'hA5A5_1234, 3, 0});
        access(1, 32'h0000_3000, 32'h0000_0077, 4'b0001, 32'h3333_4444, 0, 1,
               '{1, SIZE_BYTE, 32'h0000_3000, 4'b0001, 32'h0000_0077, 1}, '{32'hA5A5_1234, 3, 0});
        access(1, 32'h0000_3004, 32'hCAFE_F00D, 4'b1111, 32'h5555_6666, 0, 1,
               '{1, SIZE_WORD, 32'h0000_3004, 4'b1111, 32'hCAFE_F00D, 1}, '{32'hA5A5_1234, 3, 0});
        access(1, 32'h0000_3008, 32'h00AA_00BB, 4'b0101, 32'h7777_8888, 0, 1,
               '{1, SIZE_HALF, 32'h0000_3008, 4'b0101, 32'h00AA_00BB, 1}, '{32'hA5A5_1234, 3, 0});
        access(1, 32'h0000_300C, 32'h0012_3456, 4'b0111, 32'h9999_AAAA, 0, 1,
               '{1, SIZE_WORD, 32'h0000_300C, 4'b0111, 32'h0012_3456, 1}, '{32'hA5A5_1234, 3, 0});
        @(posedge clka); #1;

        // addr_ok held off for 5 extra cycles: 6 request cycles, 8 stall cycles
        access(0, 32'h0000_0101, 32'h0, 4'b0000, 32'h0BAD_F00D, 5, 1,
               '{0, SIZE_WORD, 32'h0000_0100, 4'b0000, 32'h0, 6}, '{32'h0BAD_F00D, 8, 0});
        @(posedge clka); #1;

        // Back-to-back loads
        access(0, 32'h0000_0044, 32'h0, 4'b0000, 32'h1111_1111, 0, 1,
               '{0, SIZE_WORD, 32'h0000_0044, 4'b0000, 32'h0, 1}, '{32'h1111_1111, 3, 0});
        access(0, 32'h0000_004B, 32'h0, 4'b0000, 32'h2222_2222, 0, 1,
               '{0, SIZE_WORD, 32'h0000_0048, 4'b0000, 32'h0, 1}, '{32'h2222_2222, 3, 0});
        repeat (4) @(posedge clka);
        #1;

        // Reset while in DATA, then a stray data_ok from the aborted access
        exp_bus_q.push_back('{0, SIZE_WORD, 32'h0000_0200, 4'b0000, 32'h0, 1});
        bif.cpu_en   = 1'b1;
        bif.cpu_we   = 1'b0;
        bif.cpu_addr = 32'h0000_0203;
        @(posedge clka); #1;
        chk("rst_test_req", 72'(bif.bus_req), 72'(1));
        bif.bus_addr_ok = 1'b1;
        @(posedge clka); #1;
        bif.bus_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_bus_req",   72'(bif.bus_req),   72'(0));
        chk("midrst_cpu_rdata", 72'(bif.cpu_rdata), 72'(0));
        chk("midrst_cpu_stall", 72'(bif.cpu_stall), 72'(1));
        @(posedge clka); #1;
        bif.cpu_en = 1'b0;
        @(posedge clka); #1;
        rst = 1'b0;
        bif.bus_data_ok = 1'b1;
        bif.bus_rdata   = 32'hFFFF_FFFF;
        @(posedge clka); #1;
        bif.bus_data_ok = 1'b0;
        @(posedge clka); #1;
        chk("postrst_cpu_rdata", 72'(bif.cpu_rdata), 72'(0));
        chk("postrst_bus_req",   72'(bif.bus_req),   72'(0));

        // A fresh load after reset must start from IDLE
        access(0, 32'h0000_0300, 32'h0, 4'b0000, 32'h1357_9BDF, 0, 1,
               '{0, SIZE_WORD, 32'h0000_0300, 4'b0000, 32'h0, 1}, '{32'h1357_9BDF, 3, 0});

`ifdef MEM_BRIDGE_TIMEOUT_EN
        // data_ok never comes: error at 10 cycles after ADDR entry, 12 stall cycles
        access(0, 32'h0000_0400, 32'h0, 4'b0000, 32'hDEAD_BEEF, 0, 0,
               '{0, SIZE_WORD, 32'h0000_0400, 4'b0000, 32'h0, 1}, '{32'h1357_9BDF, 12, 1});
`endif

        repeat (5) @(posedge clka);
        #1;
        chk("bus_q_drained",  72'(exp_bus_q.size()),  72'(0));
        chk("done_q_drained", 72'(exp_done_q.size()), 72'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
